demux1_4_reg: RTL and testbench



---
 rtl/demux1_4_reg.sv | 156 +++++++++++++++
 tb/tb_demux1_4_reg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_reg.sv
// demux1_4_reg: registered 1-to-4 demultiplexer for switch/button inputs.
// The 2-bit din is steered into one of four held channel registers A..D,
// addressed either manually (sel + edge-detected wr) or by a free-running
// auto-scan index that advances every SCAN_DIV clocks. seg7 shows the index
// of the channel most recently written.
// Build option: define DEMUX_CLEAR_EN to clear the non-addressed channels
// on every write.
module demux1_4_reg #(
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  input  logic [1:0] sel,
  input  logic       wr,
  input  logic       mode,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] C,
  output logic [1:0] D,
  output logic       ds,
  output logic [6:0] seg7
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Synchroniser stages
  logic [1:0] din_s1_q, din_s1_d, din_s2_q, din_s2_d;
  logic [1:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic       wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d, wr_s3_q, wr_s3_d;
  mode_e      mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;

  // Datapath state
  logic [1:0]       ch_q [4];
  logic [1:0]       ch_d [4];
  logic [1:0]       last_idx_q, last_idx_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       seg7_q, seg7_d;

  logic       we;
  logic       wr_en;
  logic [1:0] wr_addr;

  // Next-state: synchronisers, write arbitration, scan counter, seg7 decode
  always_comb begin
    din_s1_d   = din;
    din_s2_d   = din_s1_q;
    sel_s1_d   = sel;
    sel_s2_d   = sel_s1_q;
    wr_s1_d    = wr;
    wr_s2_d    = wr_s1_q;
    wr_s3_d    = wr_s2_q;
    mode_s1_d  = mode_e'(mode);
    mode_s2_d  = mode_s1_q;

    ch_d       = ch_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_addr    = '0;

    we = wr_s2_q & ~wr_s3_q;

    if (mode_s2_q == MODE_AUTO) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        wr_en   = 1'b1;
        wr_addr = idx_q;
        idx_d   = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
      if (we) begin
        wr_en   = 1'b1;
        wr_addr = sel_s2_q;
      end
    end

    if (wr_en) begin
`ifdef DEMUX_CLEAR_EN
      for (int unsigned i = 0; i < 4; i++) begin
        ch_d[i] = '0;
      end
`endif
      ch_d[wr_addr] = din_s2_q;
      last_idx_d    = wr_addr;
    end

    // Decode from the next index so the digit changes on the write edge itself
    case (last_idx_d)
      2'd0:    seg7_d = SEG_0;
      2'd1:    seg7_d = SEG_1;
      2'd2:    seg7_d = SEG_2;
      default: seg7_d = SEG_3;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_s1_q   <= '0;
      din_s2_q   <= '0;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      wr_s1_q    <= 1'b0;
      wr_s2_q    <= 1'b0;
      wr_s3_q    <= 1'b0;
      mode_s1_q  <= MODE_MANUAL;
      mode_s2_q  <= MODE_MANUAL;
      ch_q       <= '{default: '0};
      last_idx_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      seg7_q     <= SEG_0;
    end else begin
      din_s1_q   <= din_s1_d;
      din_s2_q   <= din_s2_d;
      sel_s1_q   <= sel_s1_d;
      sel_s2_q   <= sel_s2_d;
      wr_s1_q    <= wr_s1_d;
      wr_s2_q    <= wr_s2_d;
      wr_s3_q    <= wr_s3_d;
      mode_s1_q  <= mode_s1_d;
      mode_s2_q  <= mode_s2_d;
      ch_q       <= ch_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seg7_q     <= seg7_d;
    end
  end

  assign A    = ch_q[0];
  assign B    = ch_q[1];
  assign C    = ch_q[2];
  assign D    = ch_q[3];
  assign ds   = 1'b0;
  assign seg7 = seg7_q;

endmodule

// File: tb/tb_demux1_4_reg.sv
// Testbench for demux1_4_reg: directed vector table, hand-written latency
// sequences and randomized stimulus, all compared against a history-based
// reference model of the input-to-channel rules.
module tb_demux1_4_reg;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] din, sel;
  logic       wr, mode;
  logic [1:0] A, B, C, D;
  logic       ds;
  logic [6:0] seg7;

  int unsigned checks = 0;
  int unsigned errors = 0;

  demux1_4_reg #(.SCAN_DIV(SD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .sel  (sel),
    .wr   (wr),
    .mode (mode),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .ds   (ds),
    .seg7 (seg7)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] din;
    logic [1:0] sel;
    logic       wr;
    logic       mode;
  } samp_t;

  samp_t       hq[$];          // input samples taken at past edges, newest last
  logic [1:0]  m_ch [4];
  logic [1:0]  m_last;
  int unsigned auto_edges;     // edges seen with synchronised mode high
  int unsigned auto_writes;    // auto writes since entering auto mode

  function automatic logic [6:0] seg_of(input logic [1:0] i);
    case (i)
      2'd0:    return 7'b0111111;
      2'd1:    return 7'b0000110;
      2'd2:    return 7'b1011011;
      default: return 7'b1001111;
    endcase
  endfunction

  // Advance the model by one clock edge given the inputs present at it.
  // Values acting at edge n are those sampled at edge n-2 (and n-3 for wr).
  task automatic model_edge(input logic r, input samp_t cur);
    samp_t       s2, s3;
    logic        do_wr;
    logic [1:0]  addr;
    if (!r) begin
      hq.delete();
      repeat (3) hq.push_back('0);
      m_ch        = '{default: '0};
      m_last      = '0;
      auto_edges  = 0;
      auto_writes = 0;
      return;
    end
    s2    = hq[$-1];
    s3    = hq[$-2];
    do_wr = 1'b0;
    addr  = '0;
    if (s2.mode) begin
      auto_edges++;
      if (auto_edges % SD == 0) begin
        do_wr = 1'b1;
        addr  = 2'(auto_writes % 4);
        auto_writes++;
      end
    end else begin
      auto_edges  = 0;
      auto_writes = 0;
      if (s2.wr && !s3.wr) begin
        do_wr = 1'b1;
        addr  = s2.sel;
      end
    end
    if (do_wr) begin
`ifdef DEMUX_CLEAR_EN
      m_ch = '{default: '0};
`endif
      m_ch[addr] = s2.din;
      m_last     = addr;
    end
    hq.push_back(cur);
    while (hq.size() > 4) void'(hq.pop_front());
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={A,B,C,D,seg7,ds}=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {A, B, C, D, seg7, ds};
  endfunction

  // One clock edge: update model, wait for edge, compare DUT against model.
  task automatic step();
    samp_t cur;
    cur.din  = din;
    cur.sel  = sel;
    cur.wr   = wr;
    cur.mode = mode;
    model_edge(rst_n, cur);
    @(posedge clk);
    #1;
    chk("model", dut_vec(), {m_ch[0], m_ch[1], m_ch[2], m_ch[3], seg_of(m_last), 1'b0});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n;
    logic [1:0]  din;
    logic [1:0]  sel;
    logic        wr;
    logic        mode;
    int unsigned n;
    logic [1:0]  ea, eb, ec, ed;
    logic [6:0]  eseg;
  } vec_t;

  vec_t tbl[$];

`ifdef DEMUX_CLEAR_EN
  localparam logic [1:0] A_AFTER_B = 2'b00;
`else
  localparam logic [1:0] A_AFTER_B = 2'b11;
`endif

  initial begin
    rst_n = 1'b0; din = '0; sel = '0; wr = 1'b0; mode = 1'b0;
    repeat (3) hq.push_back('0);
    m_ch = '{default: '0}; m_last = '0; auto_edges = 0; auto_writes = 0;

    //              rst   din    sel    wr    mode  n   A      B      C      D      seg7
    tbl.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 3,  2'b11, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1,  2'b11, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 3,  A_AFTER_B, 2'b01, 2'b00, 2'b00, 7'b0000110});
`ifndef DEMUX_CLEAR_EN
    // manual single write with wr held
    tbl.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 10, 2'b00, 2'b00, 2'b10, 2'b00, 7'b1011011});
    tbl.push_back('{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 3,  2'b00, 2'b00, 2'b10, 2'b00, 7'b1011011});
    // manual fill
    tbl.push_back('{1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1,  2'b00, 2'b00, 2'b10, 2'b00, 7'b1011011});
    tbl.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 3,  2'b01, 2'b00, 2'b10, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 1,  2'b01, 2'b00, 2'b10, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 3,  2'b01, 2'b10, 2'b10, 2'b00, 7'b0000110});
    tbl.push_back('{1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1,  2'b01, 2'b10, 2'b10, 2'b00, 7'b0000110});
    tbl.push_back('{1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 3,  2'b01, 2'b10, 2'b11, 2'b00, 7'b1011011});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b1, 1'b0, 1,  2'b01, 2'b10, 2'b11, 2'b00, 7'b1011011});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 3,  2'b01, 2'b10, 2'b11, 2'b01, 7'b1001111});
    // auto scan with wrap, wr activity ignored
    tbl.push_back('{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 2,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 4,  2'b01, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b1, 1'b1, 4,  2'b01, 2'b01, 2'b00, 2'b00, 7'b0000110});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 4,  2'b01, 2'b01, 2'b01, 2'b00, 7'b1011011});
    tbl.push_back('{1'b1, 2'b01, 2'b11, 1'b1, 1'b1, 4,  2'b01, 2'b01, 2'b01, 2'b01, 7'b1001111});
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 4,  2'b11, 2'b01, 2'b01, 2'b01, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 4,  2'b11, 2'b11, 2'b01, 2'b01, 7'b0000110});
    // reset mid-scan, then first write 4 edges after mode_s2 re-asserts
    tbl.push_back('{1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 2,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 3,  2'b00, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1,  2'b11, 2'b00, 2'b00, 2'b00, 7'b0111111});
    // leaving auto mode keeps contents and stops scanning
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 3,  2'b11, 2'b00, 2'b00, 2'b00, 7'b0111111});
    tbl.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 4,  2'b11, 2'b00, 2'b00, 2'b00, 7'b0111111});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; din = tbl[i].din; sel = tbl[i].sel;
      wr = tbl[i].wr; mode = tbl[i].mode;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed, tbl[i].eseg, 1'b0});
    end

    // ---- hand sequence: manual latency, held wr, re-arm ----
    rst_n = 1'b0; wr = 1'b0; mode = 1'b0; step();
    rst_n = 1'b1; din = 2'b11; sel = 2'b11; wr = 1'b1;
    step(); chk("lat_k",   dut_vec(), {8'h00, 7'b0111111, 1'b0});
    step(); chk("lat_k1",  dut_vec(), {8'h00, 7'b0111111, 1'b0});
    step(); chk("lat_k2",  dut_vec(), {8'b00_00_00_11, 7'b1001111, 1'b0});
    din = 2'b01;
    repeat (6) step();
    chk("no_rewrite", dut_vec(), {8'b00_00_00_11, 7'b1001111, 1'b0});
    wr = 1'b0; step();
    wr = 1'b1; step(); step();
    chk("rearm_early", dut_vec(), {8'b00_00_00_11, 7'b1001111, 1'b0});
    step();
    chk("rearm", dut_vec(), {8'b00_00_00_01, 7'b1001111, 1'b0});

    // ---- hand sequence: auto first-write timing ----
    rst_n = 1'b0; wr = 1'b0; step();
    rst_n = 1'b1; mode = 1'b1; din = 2'b10;
    step(); step();                      // mode_s2 high after this edge
    repeat (3) step();
    chk("auto_early", dut_vec(), {8'h00, 7'b0111111, 1'b0});
    step();
    chk("auto_first", dut_vec(), {8'b10_00_00_00, 7'b0111111, 1'b0});
    repeat (3) step();
    chk("auto_gap", dut_vec(), {8'b10_00_00_00, 7'b0111111, 1'b0});
    step();
`ifdef DEMUX_CLEAR_EN
    chk("auto_second", dut_vec(), {8'b00_10_00_00, 7'b0000110, 1'b0});
`else
    chk("auto_second", dut_vec(), {8'b10_10_00_00, 7'b0000110, 1'b0});
`endif

    // ---- randomized stimulus against the model ----
    rst_n = 1'b0; mode = 1'b0; wr = 1'b0; step();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) wr = ~wr;
      if ($urandom_range(0, 2) == 0) begin
        din = 2'($urandom);
        sel = 2'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
